fabric_mem_ld_adapter: RTL and testbench
========================================

Name: fabric_mem_ld_adapter

Overview:
- Load-port adapter placed directly upstream and downstream of one tagged load port of `fabric_memory` (TAG_WIDTH > 0).
- Merges NUM_LANES untagged load-address streams into one tagged request stream using round-robin arbitration.
- Demultiplexes the returned tagged load data into per-lane response FIFOs.
- Per-lane credit counters cap outstanding loads, so the response path never back-pressures the memory.

Parameters:
- NUM_LANES, 2, number of client load lanes (>= 2).
- DATA_WIDTH, 32, address/data payload width (>= 1).
- TAG_WIDTH, 1, tag width; must be >= $clog2(NUM_LANES), else $fatal at elaboration.
- RESP_DEPTH, 2, per-lane response FIFO depth and credit limit (>= 1).
- Derived PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- lane_req_valid  in  [NUM_LANES]  per-lane load address valid.
- lane_req_ready  out  [NUM_LANES]  per-lane address accepted.
- lane_req_data  in  [NUM_LANES][DATA_WIDTH]  per-lane address.
- mem_req_valid  out  1  tagged request to the memory load-address input.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_data  out  [PAYLOAD_WIDTH]  {tag, addr}.
- mem_resp_valid  in  1  tagged load data from the memory.
- mem_resp_ready  out  1  constant 1.
- mem_resp_data  in  [PAYLOAD_WIDTH]  {tag, data}.
- lane_resp_valid  out  [NUM_LANES]  per-lane load data valid.
- lane_resp_ready  in  [NUM_LANES]  per-lane consumer ready.
- lane_resp_data  out  [NUM_LANES][DATA_WIDTH]  load data, tag stripped.
- error_valid  out  1  sticky error flag.
- error_code  out  16  code of the first error.

Behaviour:
- Reset (all state, evaluated at posedge clk with rst_n=0):
  - mem_req_valid=0, lane_resp_valid=0, error_valid=0, error_code=0.
  - All credits=0, all FIFOs empty, rr pointer=0.
  - Reset applied mid-operation discards in-flight state. Responses arriving after reset for pre-reset requests are treated as unexpected (see Errors).
- Request stage: a single output register (req_full, req_tag, req_addr).
  - The stage can load when !req_full or (mem_req_valid && mem_req_ready).
  - Lane i is eligible when lane_req_valid[i] && credit[i] < RESP_DEPTH.
  - Grant goes to the first eligible lane at or after rr_ptr, wrapping modulo NUM_LANES.
  - lane_req_ready[i] = (grant==i) && stage can load. At most one lane is ready per cycle.
  - On grant: the register loads {i, addr}, and rr_ptr becomes (i+1) mod NUM_LANES. With no grant, rr_ptr holds.
  - Latency is 1 cycle from lane handshake to mem_req_valid. Sustained throughput is 1 request per cycle when mem_req_ready=1.
  - mem_req_data is held stable while mem_req_valid && !mem_req_ready.
- Credits:
  - credit[i] increments on lane i grant and decrements on lane i response pop (lane_resp_valid && lane_resp_ready).
  - Grant and pop in the same cycle leave the credit unchanged.
  - Credits range 0..RESP_DEPTH. Never wrap.
- Response path:
  - mem_resp_ready=1 always.
  - On mem_resp_valid, the tag selects the FIFO. The payload is pushed at the posedge, so the data is visible on lane_resp_* the next cycle.
  - Each FIFO is a circular buffer with count in 0..RESP_DEPTH; pointers wrap at RESP_DEPTH-1.
  - Push and pop on the same FIFO in the same cycle: count unchanged, both pointers advance.
  - Per-lane order is FIFO, independent of other lanes.
- Errors:
  - Tag >= NUM_LANES: response dropped; err code RT_MEMORY_TAG_OOB.
  - Push to a FIFO whose pre-pop count == RESP_DEPTH, or whose credit[tag]==0: response dropped, state unchanged; err code RT_MEMORY_LD_UNEXPECTED. This code is a new entry in fabric_common.svh.
  - If both errors occur in the same cycle, TAG_OOB has priority.
  - The first error latches error_valid=1 and error_code. Later errors are ignored. Cleared only by reset.

Test Plan:
- Lane0 requests addr 0x10, mem_req_ready=1 → next cycle mem_req_valid=1 with data {tag0, 0x10}; return {0, 0xAB} → lane_resp_data[0]=0xAB valid one cycle later; credit[0] returns to 0 after pop.
- Both lanes valid continuously, mem_req_ready=1, responses echoed, consumers ready → grants alternate 0,1,0,1; each lane sees its own data in order.
- Lane1 consumer stalled, RESP_DEPTH=2 → after 2 grants lane1 is blocked (lane_req_ready[1]=0) while lane0 continues; releasing ready restores lane1 grants.
- mem_req_ready=0 for 5 cycles → mem_req_data held constant, no lane_req_ready; the request issues on the cycle ready rises.
- NUM_LANES=3, TAG_WIDTH=2: response with tag 3 → dropped, error_valid=1 and error_code=RT_MEMORY_TAG_OOB next cycle; a later unexpected response leaves the code unchanged.
- Response for lane0 with credit[0]=0 → error RT_MEMORY_LD_UNEXPECTED. Assert rst_n=0 mid-burst → all outputs and counters zero next cycle.

Source files
------------

// File: rtl/fabric_mem_ld_adapter.sv
// Load-port adapter for one tagged load port of fabric_memory.
// Round-robin merges NUM_LANES untagged address streams into a single tagged
// request register, and steers tagged load data back into per-lane FIFOs.
// Per-lane credits bound outstanding loads to the FIFO depth, so the response
// side can always accept (mem_resp_ready is tied high).
module fabric_mem_ld_adapter #(
    parameter int unsigned NUM_LANES               = 2,
    parameter int unsigned DATA_WIDTH              = 32,
    parameter int unsigned TAG_WIDTH               = 1,
    parameter int unsigned RESP_DEPTH              = 2,
    parameter logic [15:0] RT_MEMORY_TAG_OOB       = 16'h0011,
    parameter logic [15:0] RT_MEMORY_LD_UNEXPECTED = 16'h0012,
    localparam int unsigned PAYLOAD_WIDTH          = DATA_WIDTH + TAG_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_LANES-1:0]                  lane_req_valid,
    output logic [NUM_LANES-1:0]                  lane_req_ready,
    input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  lane_req_data,
    output logic                                  mem_req_valid,
    input  logic                                  mem_req_ready,
    output logic [PAYLOAD_WIDTH-1:0]              mem_req_data,
    input  logic                                  mem_resp_valid,
    output logic                                  mem_resp_ready,
    input  logic [PAYLOAD_WIDTH-1:0]              mem_resp_data,
    output logic [NUM_LANES-1:0]                  lane_resp_valid,
    input  logic [NUM_LANES-1:0]                  lane_resp_ready,
    output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  lane_resp_data,
    output logic                                  error_valid,
    output logic [15:0]                           error_code
);

    localparam int unsigned IW  = $clog2(NUM_LANES);
    localparam int unsigned IW1 = IW + 1;
    localparam int unsigned CW  = $clog2(RESP_DEPTH + 1);
    localparam int unsigned PW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(RESP_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(RESP_DEPTH - 1);
    localparam logic [IW-1:0] LAST_LN  = IW'(NUM_LANES - 1);

    if (TAG_WIDTH < $clog2(NUM_LANES)) begin : g_bad_tag_width
        $fatal(1, "fabric_mem_ld_adapter: TAG_WIDTH too small for NUM_LANES");
    end

    // Request stage register
    logic                  req_full_q, req_full_d;
    logic [TAG_WIDTH-1:0]  req_tag_q,  req_tag_d;
    logic [DATA_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [IW-1:0]         rr_q,       rr_d;

    // Credits and response FIFOs
    logic [CW-1:0]         credit_q [NUM_LANES];
    logic [CW-1:0]         credit_d [NUM_LANES];
    logic [CW-1:0]         count_q  [NUM_LANES];
    logic [CW-1:0]         count_d  [NUM_LANES];
    logic [PW-1:0]         wr_ptr_q [NUM_LANES];
    logic [PW-1:0]         wr_ptr_d [NUM_LANES];
    logic [PW-1:0]         rd_ptr_q [NUM_LANES];
    logic [PW-1:0]         rd_ptr_d [NUM_LANES];
    logic [DATA_WIDTH-1:0] fifo_q   [NUM_LANES][RESP_DEPTH];

    // Sticky error
    logic                  err_valid_q, err_valid_d;
    logic [15:0]           err_code_q,  err_code_d;

    // Combinational control
    logic                  can_load;
    logic                  grant_vld;
    logic [IW-1:0]         grant_idx;
    logic [IW:0]           cand_sum;
    logic [IW-1:0]         cand;
    logic                  req_hs;
    logic [TAG_WIDTH-1:0]  resp_tag;
    logic [DATA_WIDTH-1:0] resp_dat;
    logic                  tag_hit;
    logic                  tag_oob;
    logic                  resp_unexp;
    logic [NUM_LANES-1:0]  push;
    logic [NUM_LANES-1:0]  pop;

    assign mem_req_valid  = req_full_q;
    assign mem_req_data   = {req_tag_q, req_addr_q};
    assign mem_resp_ready = 1'b1;
    assign error_valid    = err_valid_q;
    assign error_code     = err_code_q;
    assign resp_tag       = mem_resp_data[PAYLOAD_WIDTH-1 -: TAG_WIDTH];
    assign resp_dat       = mem_resp_data[DATA_WIDTH-1:0];

    // Round-robin pick of the first eligible lane at or after rr_q
    always_comb begin
        can_load  = !req_full_q || mem_req_ready;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            cand_sum = {1'b0, rr_q} + IW1'(k);
            if (cand_sum >= IW1'(NUM_LANES)) begin
                cand_sum = cand_sum - IW1'(NUM_LANES);
            end
            cand = cand_sum[IW-1:0];
            if (!grant_vld && lane_req_valid[cand] && (credit_q[cand] < DEPTH_C)) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        req_hs         = grant_vld && can_load;
        lane_req_ready = '0;
        if (req_hs) begin
            lane_req_ready[grant_idx] = 1'b1;
        end
    end

    // Request register and round-robin pointer next state
    always_comb begin
        req_full_d = req_full_q;
        req_tag_d  = req_tag_q;
        req_addr_d = req_addr_q;
        rr_d       = rr_q;
        if (req_hs) begin
            req_full_d = 1'b1;
            req_tag_d  = TAG_WIDTH'(grant_idx);
            req_addr_d = lane_req_data[grant_idx];
            rr_d       = (grant_idx == LAST_LN) ? '0 : grant_idx + 1'b1;
        end else if (mem_req_ready) begin
            req_full_d = 1'b0;
        end
    end

    // Response steering: classify the incoming response and pick its FIFO
    always_comb begin
        tag_hit    = 1'b0;
        resp_unexp = 1'b0;
        push       = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            pop[i] = (count_q[i] != '0) && lane_resp_ready[i];
            if (resp_tag == TAG_WIDTH'(i)) begin
                tag_hit = 1'b1;
                if (mem_resp_valid) begin
                    // Full test uses the pre-pop count: a same-cycle pop does not make room
                    if ((count_q[i] == DEPTH_C) || (credit_q[i] == '0)) begin
                        resp_unexp = 1'b1;
                    end else begin
                        push[i] = 1'b1;
                    end
                end
            end
        end
        tag_oob = mem_resp_valid && !tag_hit;
    end

    // Credit, FIFO occupancy and pointer next state
    always_comb begin
        credit_d = credit_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (req_hs && (grant_idx == IW'(i)) && !pop[i]) begin
                credit_d[i] = credit_q[i] + 1'b1;
            end else if (pop[i] && !(req_hs && (grant_idx == IW'(i)))) begin
                credit_d[i] = credit_q[i] - 1'b1;
            end
            if (push[i] && !pop[i]) begin
                count_d[i] = count_q[i] + 1'b1;
            end else if (pop[i] && !push[i]) begin
                count_d[i] = count_q[i] - 1'b1;
            end
            if (push[i]) begin
                wr_ptr_d[i] = (wr_ptr_q[i] == LAST_PTR) ? '0 : wr_ptr_q[i] + 1'b1;
            end
            if (pop[i]) begin
                rd_ptr_d[i] = (rd_ptr_q[i] == LAST_PTR) ? '0 : rd_ptr_q[i] + 1'b1;
            end
        end
    end

    // First error wins; OOB outranks an unexpected response in the same cycle
    always_comb begin
        err_valid_d = err_valid_q;
        err_code_d  = err_code_q;
        if (!err_valid_q) begin
            if (tag_oob) begin
                err_valid_d = 1'b1;
                err_code_d  = RT_MEMORY_TAG_OOB;
            end else if (resp_unexp) begin
                err_valid_d = 1'b1;
                err_code_d  = RT_MEMORY_LD_UNEXPECTED;
            end
        end
    end

    // Head-of-FIFO presentation to each lane
    always_comb begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_resp_valid[i] = (count_q[i] != '0);
            lane_resp_data[i]  = fifo_q[i][rd_ptr_q[i]];
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_full_q  <= 1'b0;
            req_tag_q   <= '0;
            req_addr_q  <= '0;
            rr_q        <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                credit_q[i] <= '0;
                count_q[i]  <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            req_full_q  <= req_full_d;
            req_tag_q   <= req_tag_d;
            req_addr_q  <= req_addr_d;
            rr_q        <= rr_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            credit_q    <= credit_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are only observed while count is non-zero
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (rst_n && push[i]) begin
                fifo_q[i][wr_ptr_q[i]] <= resp_dat;
            end
        end
    end

endmodule

// File: tb/tb_fabric_mem_ld_adapter.sv
// Bench for fabric_mem_ld_adapter: 3 lanes, 2-bit tags, depth-2 FIFOs.
// A queue-based reference model is compared against every DUT output on each
// falling edge; directed scenarios add literal expectations on top.
module tb_fabric_mem_ld_adapter;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int TW = 2;
    localparam int D  = 2;
    localparam logic [15:0] OOB_C   = 16'h0011;
    localparam logic [15:0] UNEXP_C = 16'h0012;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N-1:0]           lane_req_valid;
    logic [N-1:0]           lane_req_ready;
    logic [N-1:0][DW-1:0]   lane_req_data;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [DW+TW-1:0]       mem_req_data;
    logic                   mem_resp_valid;
    logic                   mem_resp_ready;
    logic [DW+TW-1:0]       mem_resp_data;
    logic [N-1:0]           lane_resp_valid;
    logic [N-1:0]           lane_resp_ready;
    logic [N-1:0][DW-1:0]   lane_resp_data;
    logic                   error_valid;
    logic [15:0]            error_code;

    always #5 clk = ~clk;

    fabric_mem_ld_adapter #(
        .NUM_LANES(N),
        .DATA_WIDTH(DW),
        .TAG_WIDTH(TW),
        .RESP_DEPTH(D),
        .RT_MEMORY_TAG_OOB(OOB_C),
        .RT_MEMORY_LD_UNEXPECTED(UNEXP_C)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .lane_req_valid(lane_req_valid),
        .lane_req_ready(lane_req_ready),
        .lane_req_data(lane_req_data),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_ready(mem_resp_ready),
        .mem_resp_data(mem_resp_data),
        .lane_resp_valid(lane_resp_valid),
        .lane_resp_ready(lane_resp_ready),
        .lane_resp_data(lane_resp_data),
        .error_valid(error_valid),
        .error_code(error_code)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_full   = 1'b0;
    logic [1:0]  m_tag    = '0;
    logic [15:0] m_addr   = '0;
    int          m_rr     = 0;
    int          m_credit [N] = '{default: 0};
    logic [15:0] m_q      [N][$];
    bit          m_err    = 1'b0;
    logic [15:0] m_code   = '0;

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int l;
            l = (m_rr + k) % N;
            if (lane_req_valid[l] && m_credit[l] < D) return l;
        end
        return -1;
    endfunction

    // Model state advance, from the same pre-edge inputs the DUT samples
    int          u_g;
    bit          u_hs;
    bit          u_pop [N];
    bit          u_push;
    int          u_t;
    logic [15:0] u_err;
    always @(posedge clk) begin
        if (!rst_n) begin
            m_full = 1'b0; m_tag = '0; m_addr = '0; m_rr = 0;
            m_err = 1'b0; m_code = '0;
            for (int i = 0; i < N; i++) begin
                m_credit[i] = 0;
                m_q[i].delete();
            end
        end else begin
            u_g  = model_grant();
            u_hs = (u_g >= 0) && (!m_full || mem_req_ready);
            u_push = 1'b0;
            u_err  = '0;
            u_t    = int'(mem_resp_data[DW+TW-1:DW]);
            for (int i = 0; i < N; i++) u_pop[i] = (m_q[i].size() > 0) && lane_resp_ready[i];
            if (mem_resp_valid) begin
                if (u_t >= N) u_err = OOB_C;
                else if (m_q[u_t].size() == D || m_credit[u_t] == 0) u_err = UNEXP_C;
                else u_push = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (u_pop[i]) begin
                    void'(m_q[i].pop_front());
                    m_credit[i]--;
                end
            end
            if (u_push) m_q[u_t].push_back(mem_resp_data[DW-1:0]);
            if (u_hs) begin
                m_credit[u_g]++;
                m_full = 1'b1;
                m_tag  = 2'(u_g);
                m_addr = lane_req_data[u_g];
                m_rr   = (u_g + 1) % N;
            end else if (mem_req_ready) begin
                m_full = 1'b0;
            end
            if (!m_err && u_err != '0) begin
                m_err  = 1'b1;
                m_code = u_err;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    int          c_g;
    logic [N-1:0] c_rdy;
    always @(negedge clk) begin
        c_g   = model_grant();
        c_rdy = '0;
        if (c_g >= 0 && (!m_full || mem_req_ready)) c_rdy[c_g] = 1'b1;
        chk("model_lane_req_ready", 32'(lane_req_ready), 32'(c_rdy));
        chk("model_mem_req_valid", 32'(mem_req_valid), 32'(m_full));
        if (m_full) chk("model_mem_req_data", 32'(mem_req_data), 32'({m_tag, m_addr}));
        chk("model_mem_resp_ready", 32'(mem_resp_ready), 32'd1);
        for (int i = 0; i < N; i++) begin
            chk("model_lane_resp_valid", 32'(lane_resp_valid[i]), 32'(m_q[i].size() > 0));
            if (m_q[i].size() > 0) chk("model_lane_resp_data", 32'(lane_resp_data[i]), 32'(m_q[i][0]));
        end
        chk("model_error_valid", 32'(error_valid), 32'(m_err));
        chk("model_error_code", 32'(error_code), 32'(m_code));
    end

    // ---------------- stimulus ----------------
    bit          echo_en     = 1'b0;
    bit          echo_always = 1'b0;
    logic [17:0] pend [$];
    logic [N-1:0] lane_hs = '0;

    // Record accepted memory requests and lane handshakes for the responder/drivers
    always @(negedge clk) begin
        lane_hs = lane_req_valid & lane_req_ready;
        if (rst_n && echo_en && mem_req_valid && mem_req_ready) pend.push_back(mem_req_data);
    end

    task automatic tick();
        logic [17:0] p;
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        if (echo_en && pend.size() > 0 && (echo_always || $urandom_range(0, 3) != 0)) begin
            p = pend.pop_front();
            mem_resp_valid = 1'b1;
            mem_resp_data  = {p[17:16], p[15:0] ^ 16'h5A5A};
        end
    endtask

    task automatic reset_pulse();
        echo_en = 1'b0;
        pend.delete();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int prev_g;
    int cnt0;
    bit seen;

    initial begin
        rst_n           = 1'b0;
        lane_req_valid  = '0;
        lane_req_data   = '0;
        mem_req_ready   = 1'b0;
        mem_resp_valid  = 1'b0;
        mem_resp_data   = '0;
        lane_resp_ready = '1;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_lane_resp_valid", 32'(lane_resp_valid), 32'd0);
        chk("rst_error_valid", 32'(error_valid), 32'd0);
        chk("rst_error_code", 32'(error_code), 32'd0);

        // Single load on lane 0
        tick();
        rst_n = 1'b1;
        lane_req_valid = 3'b001;
        lane_req_data[0] = 16'h0010;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("t1_lane_req_ready", 32'(lane_req_ready), 32'b001);
        tick();
        lane_req_valid = '0;
        @(negedge clk);
        chk("t1_mem_req_valid", 32'(mem_req_valid), 32'd1);
        chk("t1_mem_req_data", 32'(mem_req_data), 32'h00010);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = {2'd0, 16'h00AB};
        @(negedge clk);
        chk("t1_resp_not_yet", 32'(lane_resp_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("t1_lane_resp_valid", 32'(lane_resp_valid), 32'b001);
        chk("t1_lane_resp_data", 32'(lane_resp_data[0]), 32'h00AB);
        tick();
        @(negedge clk);
        chk("t1_popped", 32'(lane_resp_valid), 32'd0);

        // Out-of-range tag, then an unexpected response that must not overwrite the code
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = {2'd3, 16'h1234};
        @(negedge clk);
        chk("t2_err_before", 32'(error_valid), 32'd0);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = {2'd0, 16'h0001};
        @(negedge clk);
        chk("t2_err_valid", 32'(error_valid), 32'd1);
        chk("t2_err_oob", 32'(error_code), 32'(OOB_C));
        tick();
        @(negedge clk);
        chk("t2_code_sticky", 32'(error_code), 32'(OOB_C));
        chk("t2_dropped", 32'(lane_resp_valid), 32'd0);

        // Response to a lane with zero credit after reset
        reset_pulse();
        @(negedge clk);
        chk("t3_err_cleared", 32'(error_valid), 32'd0);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = {2'd0, 16'h0077};
        tick();
        @(negedge clk);
        chk("t3_err_valid", 32'(error_valid), 32'd1);
        chk("t3_err_unexp", 32'(error_code), 32'(UNEXP_C));
        reset_pulse();

        // Memory back-pressure holds the request register
        tick();
        mem_req_ready = 1'b0;
        lane_req_valid = 3'b001;
        lane_req_data[0] = 16'h0055;
        @(negedge clk);
        chk("t4_first_accept", 32'(lane_req_ready), 32'b001);
        tick();
        lane_req_valid = 3'b010;
        lane_req_data[1] = 16'h0066;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(mem_req_valid), 32'd1);
            chk("t4_hold_data", 32'(mem_req_data), 32'h00055);
            chk("t4_no_ready", 32'(lane_req_ready), 32'd0);
            tick();
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("t4_release_ready", 32'(lane_req_ready), 32'b010);
        chk("t4_release_data", 32'(mem_req_data), 32'h00055);
        tick();
        lane_req_valid = '0;
        @(negedge clk);
        chk("t4_next_req", 32'(mem_req_data), 32'h10066);
        reset_pulse();

        // Two lanes contending: grants alternate
        mem_req_ready = 1'b1;
        echo_en = 1'b1;
        echo_always = 1'b1;
        lane_req_valid = 3'b011;
        lane_req_data[0] = 16'(($urandom));
        lane_req_data[1] = 16'(($urandom));
        prev_g = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (lane_req_ready != '0) begin
                if (prev_g >= 0) chk("t5_alternate", 32'(lane_req_ready), 32'(prev_g == 0 ? 3'b010 : 3'b001));
                prev_g = lane_req_ready[1] ? 1 : 0;
            end
            tick();
            for (int l = 0; l < 2; l++) if (lane_hs[l]) lane_req_data[l] = 16'($urandom);
        end

        // Lane 1 consumer stalls: lane 1 runs out of credit, lane 0 keeps going
        lane_resp_ready = 3'b101;
        for (int i = 0; i < 20; i++) begin
            tick();
            for (int l = 0; l < 2; l++) if (lane_hs[l]) lane_req_data[l] = 16'($urandom);
        end
        cnt0 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_lane1_blocked", 32'(lane_req_ready[1]), 32'd0);
            if (lane_req_ready[0]) cnt0++;
            tick();
            for (int l = 0; l < 2; l++) if (lane_hs[l]) lane_req_data[l] = 16'($urandom);
        end
        chk("t6_lane0_progress", 32'(cnt0 >= 2), 32'd1);
        @(negedge clk);
        chk("t6_lane1_full", 32'(lane_resp_valid[1]), 32'd1);
        lane_resp_ready = 3'b111;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            for (int l = 0; l < 2; l++) if (lane_hs[l]) lane_req_data[l] = 16'($urandom);
            @(negedge clk);
            if (lane_req_ready[1]) seen = 1'b1;
        end
        chk("t6_lane1_resumes", 32'(seen), 32'd1);

        // Random traffic with a reset in the middle of the burst
        echo_always = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            tick();
            if (i == 700) begin
                echo_en = 1'b0;
                pend.delete();
                mem_resp_valid = 1'b0;
                rst_n = 1'b0;
            end else if (i == 701) begin
                rst_n = 1'b1;
                pend.delete();
                echo_en = 1'b1;
                @(negedge clk);
                chk("t7_rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
                chk("t7_rst_lane_resp_valid", 32'(lane_resp_valid), 32'd0);
                chk("t7_rst_error_valid", 32'(error_valid), 32'd0);
                @(posedge clk);
                #1;
            end
            mem_req_ready   = ($urandom_range(0, 3) != 0);
            lane_resp_ready = 3'($urandom);
            for (int l = 0; l < N; l++) begin
                if (!lane_req_valid[l] || lane_hs[l]) begin
                    lane_req_valid[l] = ($urandom_range(0, 99) < 60);
                    lane_req_data[l]  = 16'($urandom);
                end
            end
        end
        @(negedge clk);
        chk("t7_no_error", 32'(error_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
